// File: rtl/cmodule_stream_source.sv
`default_nettype none
// ============================================================================
//  Module   : cmodule_stream_source
//  Purpose  : Bridge that lets a C source model drive a valid/ready stream.
//             On every enabled rising edge the C model is told whether the
//             FIFO can take a word, is clocked, and then is asked for one
//             optional word. Accepted words are buffered in a DEPTH-entry
//             FIFO. Words the C side produces with no room are dropped and
//             counted.
//  Ports    : clk          - clock; all C calls happen on its rising edge
//             rst_n        - asynchronous active-low reset
//             i_enable     - 0 freezes the C model (no calls at all)
//             o_valid      - FIFO non-empty
//             i_ready      - downstream accepts o_data
//             o_data       - FIFO head word, 0 when empty
//             o_level      - FIFO occupancy
//             o_overflow   - sticky: a word arrived with no space
//             o_drop_count - saturating count of dropped words
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// C-model access layer: an in-language source model that emits queued words
// one per clock, honouring the credit unless told to ignore it.
// ----------------------------------------------------------------------------
package cmodule_stream_source_cmodel_pkg;
    typedef int unsigned cm_handle_t;

    int unsigned n_create      = 0;
    int unsigned n_clock       = 0;
    string       last_kind     = "";
    string       last_path     = "";
    bit          credit_seen   = 1'b0;
    bit          ignore_credit = 1'b0;
    logic [31:0] pending[$];
    logic        out_valid     = 1'b0;
    logic [31:0] out_data      = '0;

    function automatic cm_handle_t createCModule(input string kind, input string path);
        n_create++;
        last_kind = kind;
        last_path = path;
        return n_create;
    endfunction

    function automatic void PUSH_TO_C(input cm_handle_t h, input bit credit);
        if (h != 0) credit_seen = credit;
    endfunction

    function automatic void CLOCK_CMODULE(input cm_handle_t h, input bit clk);
        if (h != 0 && clk) begin
            n_clock++;
            out_valid = 1'b0;
            out_data  = '0;
            if (pending.size() != 0 && (credit_seen || ignore_credit)) begin
                out_valid = 1'b1;
                out_data  = pending.pop_front();
            end
        end
    endfunction

    function automatic logic POP_FROM_C_VALID(input cm_handle_t h);
        return (h != 0) ? out_valid : 1'b0;
    endfunction

    function automatic int unsigned POP_FROM_C_DATA(input cm_handle_t h);
        return (h != 0) ? out_data : 32'd0;
    endfunction
endpackage

module cmodule_stream_source #(
    parameter int    WIDTH  = 17,
    parameter int    DEPTH  = 4,
    parameter string CMODEL = "source"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [7:0]               o_drop_count
);
    import cmodule_stream_source_cmodel_pkg::*;

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cmodule_stream_source: DEPTH must be a power of two >= 2");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("cmodule_stream_source: WIDTH must be 1..32 (C word is 32 bits)");
    end

    typedef struct packed {
        logic [DEPTH-1:0][WIDTH-1:0] mem;
        logic [c_AW-1:0]             wr_ptr;
        logic [c_AW-1:0]             rd_ptr;
        logic [c_LW-1:0]             level;
        logic                        overflow;
        logic [7:0]                  drops;
    } fifo_t;

    // Created once at time zero, outside reset, so the C instance survives
    // any number of rst_n pulses.
    cm_handle_t cm_handle = createCModule(CMODEL, $sformatf("%m"));

    fifo_t state_q;

    logic          w_deq;
    logic [c_LW:0] w_after_deq;
    logic          w_space;

    assign o_valid      = (state_q.level != '0);
    assign o_data       = o_valid ? state_q.mem[state_q.rd_ptr] : '0;
    assign o_level      = state_q.level;
    assign o_overflow   = state_q.overflow;
    assign o_drop_count = state_q.drops;

    // A full FIFO that is being drained this edge still has room for one.
    assign w_deq       = o_valid & i_ready;
    assign w_after_deq = {1'b0, state_q.level} - (c_LW + 1)'(w_deq);
    assign w_space     = (w_after_deq < (c_LW + 1)'(DEPTH));

    // One full C transaction for this edge, in the fixed call order.
    // Returns {valid, data}; an unknown valid is treated as no word.
    function automatic logic [WIDTH:0] cm_step(input logic space);
        logic             v;
        logic [WIDTH-1:0] d;
        PUSH_TO_C(cm_handle, space);
        CLOCK_CMODULE(cm_handle, 1'b1);
        v = POP_FROM_C_VALID(cm_handle);
        d = WIDTH'(POP_FROM_C_DATA(cm_handle));
        if ($isunknown(v)) begin
            $error("cmodule_stream_source: C model returned unknown valid");
            v = 1'b0;
        end
        return {v, d};
    endfunction

    // Next FIFO state from the current state, the dequeue decision, the
    // credit, and the word (if any) offered by the C side.
    function automatic fifo_t fifo_next(input fifo_t s, input logic deq,
                                        input logic space, input logic [WIDTH:0] src);
        fifo_t n;
        logic  enq;
        logic  drop;
        n    = s;
        enq  = src[WIDTH] & space;
        drop = src[WIDTH] & ~space;
        if (enq) begin
            n.mem[s.wr_ptr] = src[WIDTH-1:0];
            n.wr_ptr        = s.wr_ptr + 1'b1;
        end
        if (deq) begin
            n.rd_ptr = s.rd_ptr + 1'b1;
        end
        n.level = s.level + c_LW'(enq) - c_LW'(deq);
        if (drop) begin
            n.overflow = 1'b1;
            if (s.drops != 8'hFF) n.drops = s.drops + 8'd1;
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else if (i_enable) begin
            state_q <= fifo_next(state_q, w_deq, w_space, cm_step(w_space));
        end else begin
            state_q <= fifo_next(state_q, w_deq, w_space, '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmodule_stream_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmodule_stream_source
//  Purpose  : Scoreboard bench for cmodule_stream_source. Words handed to the
//             C source are mirrored in a script queue; a reference model of
//             the bridge (plain queues and counters) decides at each edge
//             which words are accepted or dropped and pushes accepted words
//             into the expected queue. The monitor pops on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmodule_stream_source;
    import cmodule_stream_source_cmodel_pkg::*;

    localparam int WIDTH = 17;
    localparam int DEPTH = 4;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             i_enable = 1'b1;
    logic             i_ready  = 1'b0;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [2:0]       o_level;
    logic             o_overflow;
    logic [7:0]       o_drop_count;

    cmodule_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CMODEL("source")) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_level      (o_level),
        .o_overflow   (o_overflow),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];     // scoreboard: words the bridge must deliver
    logic [WIDTH-1:0] script[$];    // words the C source still has to emit
    bit               ign        = 1'b0;
    bit               ref_ovf    = 1'b0;
    int               ref_drops  = 0;
    int               ref_clocks = 0;
    bit               last_en    = 1'b0;
    bit               last_space = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic src_push(input logic [WIDTH-1:0] w);
        script.push_back(w);
        pending.push_back(32'(w));
    endtask

    task automatic set_ign(input bit b);
        ign           = b;
        ignore_credit = b;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        ref_ovf   = 1'b0;
        ref_drops = 0;
        last_en   = 1'b0;
    endtask

    // Monitor + reference model. Outputs are checked mid-cycle; then the
    // model decides what the coming rising edge does with the current inputs.
    always @(negedge clk) begin
        bit deq;
        bit space;
        chk("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        chk("level", 32'(o_level), 32'(exp_q.size()));
        chk("head",  32'(o_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        chk("overflow", 32'(o_overflow), 32'(ref_ovf));
        chk("drop_count", 32'(o_drop_count), 32'(ref_drops));
        chk("c_clock_calls", n_clock, 32'(ref_clocks));
        if (last_en) chk("c_credit", 32'(credit_seen), 32'(last_space));
        if (rst_n) begin
            deq   = (exp_q.size() != 0) && i_ready;
            space = (int'(exp_q.size()) - int'(deq)) < DEPTH;
            if (deq) void'(exp_q.pop_front());
            last_en = i_enable;
            if (i_enable) begin
                ref_clocks++;
                last_space = space;
                if (script.size() != 0 && (space || ign)) begin
                    logic [WIDTH-1:0] w;
                    w = script.pop_front();
                    if (space) begin
                        exp_q.push_back(w);
                    end else begin
                        ref_ovf = 1'b1;
                        if (ref_drops < 255) ref_drops++;
                    end
                end
            end
        end else begin
            last_en = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held for three edges with the C side enabled
        #1;
        rst_n = 1'b0;
        model_reset();
        edges(3);
        chk("reset_c_calls", n_clock, 32'd0);
        rst_n = 1'b1;

        // Streaming 1,2,3
        i_ready = 1'b1;
        src_push(17'd1); src_push(17'd2); src_push(17'd3);
        edges(6);

        // Backpressure: 10..15 with credit honoured
        i_ready = 1'b0;
        for (int i = 10; i <= 15; i++) src_push(WIDTH'(i));
        edges(7);
        chk("bp_level_full", 32'(o_level), 32'd4);
        chk("bp_credit_zero", 32'(credit_seen), 32'd0);
        i_ready = 1'b1;
        edges(8);

        // Misbehaving C: ignores credit while full
        i_ready = 1'b0;
        for (int i = 30; i <= 33; i++) src_push(WIDTH'(i));
        edges(5);
        set_ign(1'b1);
        src_push(17'h1FFFF);
        edges(2);
        chk("drop_one", 32'(o_drop_count), 32'd1);
        chk("drop_head", 32'(o_data), 32'd30);
        set_ign(1'b0);
        i_ready = 1'b1;
        edges(6);

        // Drop counter saturation
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) src_push(WIDTH'(16'h0200 + i));
        edges(5);
        set_ign(1'b1);
        for (int i = 0; i < 260; i++) src_push(WIDTH'(16'h0100 + i));
        edges(262);
        chk("drop_saturated", 32'(o_drop_count), 32'd255);
        set_ign(1'b0);
        i_ready = 1'b1;
        edges(8);

        // Full with simultaneous dequeue
        i_ready = 1'b0;
        for (int i = 40; i <= 43; i++) src_push(WIDTH'(i));
        edges(5);
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) src_push(17'd20);
        edges(4);
        chk("full_deq_level", 32'(o_level), 32'd4);
        edges(8);

        // Mid-stream asynchronous reset with three words buffered
        i_ready = 1'b0;
        src_push(17'd50); src_push(17'd51); src_push(17'd52);
        edges(4);
        chk("pre_reset_level", 32'(o_level), 32'd3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_valid", 32'(o_valid), 32'd0);
        chk("async_reset_level", 32'(o_level), 32'd0);
        chk("async_reset_ovf", 32'(o_overflow), 32'd0);
        src_push(17'd60);
        edges(2);
        rst_n   = 1'b1;
        i_ready = 1'b1;
        edges(1);
        chk("first_after_reset", 32'(o_data), 32'd60);
        edges(4);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            i_ready  = ($urandom_range(0, 3) != 0);
            i_enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) src_push(WIDTH'($urandom_range(0, 32'h1FFFF)));
            set_ign($urandom_range(0, 15) == 0);
            edges(1);
        end
        set_ign(1'b0);
        i_enable = 1'b1;
        i_ready  = 1'b1;
        edges(250);

        chk("c_pending_drained", 32'(pending.size()), 32'd0);
        chk("c_handle_created_once", n_create, 32'd1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
